truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//   Exhaustive stimulus/check stage wrapped around a small combinational gate (e.g. decoder-built OR).
//   Upstream side drives every N_IN-bit input combination in ascending order; downstream side samples the gate output.
//   Builds the observed truth table and compares it against an expected mask latched at start.
//   Reports pass/fail and the first mismatching index.
// PARAMETERS
//   N_IN    2   number of gate inputs; table width is 2**N_IN
//   SETTLE  1   cycles each vector is held before sampling (legal range >= 1)
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous, active-high reset
//   start      in   1           begin a scan; sampled only in IDLE
//   expected   in   2**N_IN     expected truth table; bit i = gate output for stim == i; latched on start
//   stim       out  N_IN        registered drive to the gate inputs (stim[N_IN-1] = MSB; for N_IN=2: A=stim[1], B=stim[0])
//   gate_y     in   1           gate output under test
//   busy       out  1           scan in progress
//   done       out  1           single-cycle pulse: scan complete, pass/fail_idx valid
//   pass       out  1           1 = table_out == expected; held until next start
//   table_out  out  2**N_IN     observed truth table; held until next start
//   fail_idx   out  N_IN        lowest mismatching index; 0 when pass
// BEHAVIOUR
//   Reset: state=IDLE; stim, busy, done, pass, table_out, fail_idx, settle counter and expected latch all 0.
//     rst overrides every other input, including start in the same cycle.
//   States:
//     IDLE -> SETTLE when start=1 (cycle 0).
//       On this edge: expected is latched, table_out cleared to 0, stim=0, counter=0.
//     SETTLE: counter increments each cycle; -> SAMPLE after SETTLE cycles in SETTLE.
//     SAMPLE: table_out[stim] <= gate_y.
//       If stim == 2**N_IN-1 -> COMPARE.
//       Otherwise stim <= stim+1, counter=0, -> SETTLE.
//     COMPARE: pass <= (table_out == expected latch); fail_idx <= lowest mismatching bit index (0 if none);
//       done <= 1; busy <= 0; stim <= 0; -> IDLE.
//   Timing:
//     Each vector occupies exactly SETTLE+1 cycles.
//     stim changes only on SETTLE entry, so it is stable for the whole sample window.
//     busy=1 from cycle 1 through the COMPARE cycle.
//     done=1 in cycle 2**N_IN*(SETTLE+1)+2 only; busy is 0 in that cycle.
//     Next start is accepted in the done cycle (state is IDLE).
//   Boundaries:
//     start while busy is ignored; expected may change mid-scan without effect.
//     rst mid-scan aborts the scan: no done pulse, all outputs return to reset values the next cycle.
//     stim wraps only via COMPARE; it is never incremented past 2**N_IN-1.
//   Widths: counter is $clog2(SETTLE+1) bits; all comparisons are unsigned.
// TESTING
//   1 Reset: rst=1 for 2 cycles with start=1 -> busy=done=pass=0, stim=0, table_out=0 throughout.
//   2 OR gate, expected=4'b1110, SETTLE=1, start at cycle 0
//       -> stim 0,0,1,1,2,2,3,3 over cycles 1-8; busy 1-9; done pulse at cycle 10;
//          pass=1, table_out=4'b1110, fail_idx=0.
//   3 AND gate substituted, expected=4'b1110
//       -> done at cycle 10, table_out=4'b1000, pass=0, fail_idx=1.
//   4 Scenario 2 plus start=1 and expected=4'b0000 at cycle 4
//       -> ignored; single done at cycle 10, pass=1.
//   5 Scenario 2 with rst=1 at cycle 5
//       -> cycle 6: busy=0, stim=0, table_out=0; no done.
//          Restart at cycle 7 -> done at cycle 17, pass=1.
//   6 SETTLE=3, OR gate, expected=4'b1110
//       -> each stim held 4 cycles; done at cycle 18, pass=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive truth-table scan and compare around a small combinational gate
module truth_table_scanner #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      stim,
  input  logic                 gate_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int W  = 2**N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_COMPARE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N_IN-1:0] stim_n;
  logic            busy_n, done_n, pass_n;
  logic [W-1:0]    table_n;
  logic [N_IN-1:0] idx_n;
  logic [W-1:0]    exp_q, exp_n;
  logic [W-1:0]    diff;
  logic [N_IN-1:0] first_diff;

  // Descending scan so the lowest set bit wins; stays 0 when tables agree.
  always_comb begin
    diff       = table_out ^ exp_q;
    first_diff = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) first_diff = N_IN'(i);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stim_n  = stim;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    table_n = table_out;
    idx_n   = fail_idx;
    exp_n   = exp_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SETTLE;
          exp_n   = expected;
          table_n = '0;
          stim_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          idx_n   = '0;
        end
      end
      S_SETTLE: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CNT_LAST) state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_n[stim] = gate_y;
        if (stim == STIM_LAST) begin
          state_n = S_COMPARE;
        end else begin
          stim_n  = stim + N_IN'(1);
          cnt_n   = '0;
          state_n = S_SETTLE;
        end
      end
      S_COMPARE: begin
        pass_n  = (table_out == exp_q);
        idx_n   = first_diff;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        stim_n  = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= '0;
      fail_idx  <= '0;
      exp_q     <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stim      <= stim_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      table_out <= table_n;
      fail_idx  <= idx_n;
      exp_q     <= exp_n;
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scoreboard bench for truth_table_scanner (SETTLE=1 and SETTLE=3 instances)
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [3:0] expected1, expected3;
  logic [1:0] stim1, stim3;
  logic       y1, y3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [3:0] table1, table3;
  logic [1:0] idx1, idx3;
  logic       gate_and;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    int         at;
    logic       pass;
    logic [3:0] tbl;
    logic [1:0] idx;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y1 = gate_and ? (stim1[1] & stim1[0]) : (stim1[1] | stim1[0]);
  assign y3 = stim3[1] | stim3[0];

  truth_table_scanner #(.N_IN(2), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .stim(stim1),
    .gate_y(y1), .busy(busy1), .done(done1), .pass(pass1), .table_out(table1), .fail_idx(idx1)
  );

  truth_table_scanner #(.N_IN(2), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .expected(expected3), .stim(stim3),
    .gate_y(y3), .busy(busy3), .done(done3), .pass(pass3), .table_out(table3), .fail_idx(idx3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_done_cycle", cyc, e.at);
        chk("u1_busy_at_done", busy1, 0);
        chk("u1_pass", pass1, e.pass);
        chk("u1_table", table1, e.tbl);
        chk("u1_fail_idx", idx1, e.idx);
      end
    end
    if (!rst && done3) begin
      if (q3.size() == 0) begin
        chk("u3_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("u3_done_cycle", cyc, e.at);
        chk("u3_busy_at_done", busy3, 0);
        chk("u3_pass", pass3, e.pass);
        chk("u3_table", table3, e.tbl);
        chk("u3_fail_idx", idx3, e.idx);
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, q1.size() + q3.size(), 0);
    repeat (3) tick();
  endtask

  // One SETTLE=1 scan; optional stray start at cycle 4 and per-cycle stim/busy checks.
  task automatic scan1(input logic use_and, input logic [3:0] exp_tbl, input logic exp_pass,
                       input logic [3:0] exp_table, input logic [1:0] exp_idx, input logic stray);
    int t0;
    gate_and  = use_and;
    expected1 = exp_tbl;
    start1    = 1'b1;
    t0        = cyc;
    q1.push_back('{t0 + 10, exp_pass, exp_table, exp_idx});
    for (int k = 1; k <= 9; k++) begin
      tick();
      start1 = 1'b0;
      if (stray && k == 4) begin
        start1    = 1'b1;
        expected1 = 4'b0000;
      end
      chk("u1_stim_seq", stim1, (k <= 8) ? (k - 1) / 2 : 3);
      chk("u1_busy_seq", busy1, 1);
    end
    start1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1;
    expected1 = 4'b1111; expected3 = 4'b1111; gate_and = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst_stim", stim1, 0);
      chk("rst_table", table1, 0);
      chk("rst_busy3", busy3, 0);
    end
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    repeat (2) tick();

    scan1(1'b0, 4'b1110, 1'b1, 4'b1110, 2'd0, 1'b0);
    drain("or_scan");
    scan1(1'b1, 4'b1110, 1'b0, 4'b1000, 2'd1, 1'b0);
    drain("and_scan");
    scan1(1'b0, 4'b1110, 1'b1, 4'b1110, 2'd0, 1'b1);
    drain("stray_start");

    begin
      int t0;
      gate_and  = 1'b0;
      expected1 = 4'b1110;
      start1    = 1'b1;
      t0        = cyc;
      tick();
      start1 = 1'b0;
      while (cyc < t0 + 5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy1, 0);
      chk("abort_stim", stim1, 0);
      chk("abort_table", table1, 0);
      tick();
      start1 = 1'b1;
      q1.push_back('{t0 + 17, 1'b1, 4'b1110, 2'd0});
      tick();
      start1 = 1'b0;
      drain("abort_restart");
    end

    begin
      int t0;
      expected3 = 4'b1110;
      start3    = 1'b1;
      t0        = cyc;
      q3.push_back('{t0 + 18, 1'b1, 4'b1110, 2'd0});
      for (int k = 1; k <= 16; k++) begin
        tick();
        start3 = 1'b0;
        chk("u3_stim_seq", stim3, (k - 1) / 4);
      end
      drain("settle3");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
